fc_layer_ctrl: RTL

Sequencer for one fully-connected layer. It accepts one input vector of PREVIOUS_LAYER_HEIGHT words over a ready/valid stream and broadcasts each word to every fc_neuron in the layer. It drives the shared weight/bias ROM address, sum_en and add_bias so that ROM output and data arrive aligned at each neuron. Once the last product has been accumulated, it raises a valid handshake to the next layer.

---
 rtl/fc_pkg.sv | 29 ++
 rtl/fc_layer_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for fully-connected layer sequencing: controller state
// encoding and the weight/bias ROM layout used by the controller and ROM init.
package fc_pkg;

  typedef enum logic [1:0] {
    S_BIAS  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } fc_ctrl_state_t;

  // ROM layout for a layer fed by h input words: weights 0..h-1, then the bias.
  function automatic int fc_weight_base();
    return 0;
  endfunction

  function automatic int fc_bias_addr(input int h);
    return h;
  endfunction

  function automatic int fc_rom_depth(input int h);
    return h + 1;
  endfunction

  function automatic int fc_addr_bits(input int h);
    return $clog2(h + 1);
  endfunction

endpackage

// File: rtl/fc_layer_ctrl.sv
// Sequencer for one fully-connected layer: streams H input words to all neurons,
// keeps the shared weight/bias ROM address one cycle ahead of data/sum_en/add_bias.
//
// Handshakes: a word transfers on a rising clk_i edge where valid_i && ready_o;
// a finished vector transfers on an edge where valid_o && ready_i. Neither
// ready_o nor valid_o depends combinationally on the opposite side's signals.
module fc_layer_ctrl
  import fc_pkg::*;
#(
  parameter int WORD_SIZE             = 16,
  parameter int PREVIOUS_LAYER_HEIGHT = 4,
  parameter int ALU_LATENCY           = 1,
  localparam int RAM_ADDRESS_BITS     = $clog2(PREVIOUS_LAYER_HEIGHT + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic signed [WORD_SIZE-1:0]   data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic signed [WORD_SIZE-1:0]   data_o,
  output logic [RAM_ADDRESS_BITS-1:0]   w_addr_o,
  output logic                          sum_en_o,
  output logic                          add_bias_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output fc_ctrl_state_t                state_o
);

  localparam int DRAIN_BITS = $clog2(ALU_LATENCY + 1);
  localparam logic [RAM_ADDRESS_BITS-1:0] BIAS_ADDR =
    RAM_ADDRESS_BITS'(fc_bias_addr(PREVIOUS_LAYER_HEIGHT));
  localparam logic [RAM_ADDRESS_BITS-1:0] LAST_CNT =
    RAM_ADDRESS_BITS'(PREVIOUS_LAYER_HEIGHT - 1);
  localparam logic [DRAIN_BITS-1:0] DRAIN_LAST = DRAIN_BITS'(ALU_LATENCY - 1);

  fc_ctrl_state_t                 state_q, state_d;
  logic [RAM_ADDRESS_BITS-1:0]    cnt_q, cnt_d;
  logic [DRAIN_BITS-1:0]          drain_q, drain_d;
  logic signed [WORD_SIZE-1:0]    data_q, data_d;
  logic                           sum_en_q, sum_en_d;
  logic                           add_bias_q, add_bias_d;
  logic                           accept;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_BIAS;
      cnt_q      <= '0;
      drain_q    <= '0;
      data_q     <= '0;
      sum_en_q   <= 1'b0;
      add_bias_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      data_q     <= data_d;
      sum_en_q   <= sum_en_d;
      add_bias_q <= add_bias_d;
    end
  end

  // The ROM read registers the address, so every neuron-facing control is
  // launched here and lands together with the ROM word one cycle later.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    data_d     = data_q;
    sum_en_d   = 1'b0;
    add_bias_d = 1'b0;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    w_addr_o   = '0;
    accept     = 1'b0;

    case (state_q)
      S_BIAS: begin
        w_addr_o   = BIAS_ADDR;
        add_bias_d = 1'b1;
        state_d    = S_ACCUM;
      end

      S_ACCUM: begin
        ready_o  = 1'b1;
        w_addr_o = cnt_q;
        accept   = valid_i;
        if (accept) begin
          data_d   = data_i;
          sum_en_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + RAM_ADDRESS_BITS'(1);
          end
        end
      end

      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          state_d = S_OUT;
        end else begin
          drain_d = drain_q + DRAIN_BITS'(1);
        end
      end

      S_OUT: begin
        // Returning through S_BIAS reloads every accumulator, so no clear is needed.
        valid_o = 1'b1;
        if (ready_i) begin
          state_d = S_BIAS;
        end
      end

      default: begin
        state_d = S_BIAS;
      end
    endcase
  end

  assign data_o     = data_q;
  assign sum_en_o   = sum_en_q;
  assign add_bias_o = add_bias_q;
  assign state_o    = state_q;

  a_bias_sum_exclusive: assert property (
    @(posedge clk_i) disable iff (reset_i) !(add_bias_o && sum_en_o));
  a_cnt_range: assert property (
    @(posedge clk_i) disable iff (reset_i) cnt_q <= LAST_CNT);
  a_addr_range: assert property (
    @(posedge clk_i) disable iff (reset_i) w_addr_o <= BIAS_ADDR);

endmodule
